// File: rtl/conv_kernel_mac.sv
// conv_kernel_mac: sequential signed multiply-accumulate for one convolution
// window (3x3 or 5x5), NMUL products per cycle. The accumulator is rescaled
// by an arithmetic right shift and then saturated to NBITS.
// Optional build macro CONV_RELU_EN clamps negative results to zero.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a window; in_ready=1
// MAC    | NCYC accumulate cycles, then one cycle to rescale and saturate
// DONE   | result held with out_valid=1 until out_ready
module conv_kernel_mac #(
  parameter int NBITS = 20,
  parameter int NMUL  = 3,
  parameter int SHIFT = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:24][NBITS-1:0] pixels,
  input  logic [0:24][NBITS-1:0] weights,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NBITS-1:0]       result,
  output logic                   busy
);

  localparam int PW = 2 * NBITS;
  localparam int AW = 2 * NBITS + 5;
  localparam logic [4:0] NCYC3 = 5'((9 + NMUL - 1) / NMUL);
  localparam logic [4:0] NCYC5 = 5'((25 + NMUL - 1) / NMUL);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic                    mode_q, mode_d;
  logic [0:24][NBITS-1:0]  pix_q, pix_d;
  logic [0:24][NBITS-1:0]  wgt_q, wgt_d;
  logic [NBITS-1:0]        result_q, result_d;
  logic                    out_valid_q, out_valid_d;
  logic                    in_ready_q, in_ready_d;

  logic [4:0]              n_taps;
  logic [4:0]              last_cnt;
  logic [4:0]              idx;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    mac_sum;
  logic signed [AW-1:0]    shifted;
  logic [NBITS-1:0]        sat_val;
  logic [NBITS-1:0]        post_val;

  assign n_taps   = mode_q ? 5'd25 : 5'd9;
  assign last_cnt = mode_q ? NCYC5 : NCYC3;

  // Sum of this cycle's NMUL products; taps past the kernel size add zero
  always_comb begin
    mac_sum = '0;
    idx     = '0;
    prod    = '0;
    for (int j = 0; j < NMUL; j++) begin
      if (int'(cnt_q) * NMUL + j < int'(n_taps)) begin
        idx     = 5'(int'(cnt_q) * NMUL + j);
        prod    = $signed(pix_q[idx]) * $signed(wgt_q[idx]);
        mac_sum = mac_sum + {{(AW-PW){prod[PW-1]}}, prod};
      end
    end
  end

  // Rescale (floor shift), saturate, optional ReLU
  always_comb begin
    shifted = acc_q >>> SHIFT;
    if (!shifted[AW-1] && (|shifted[AW-2:NBITS-1]))
      sat_val = {1'b0, {(NBITS-1){1'b1}}};
    else if (shifted[AW-1] && !(&shifted[AW-2:NBITS-1]))
      sat_val = {1'b1, {(NBITS-1){1'b0}}};
    else
      sat_val = shifted[NBITS-1:0];
`ifdef CONV_RELU_EN
    post_val = sat_val[NBITS-1] ? '0 : sat_val;
`else
    post_val = sat_val;
`endif
  end

  // Next-state, capture and accumulate logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mode_d      = mode_q;
    pix_d       = pix_q;
    wgt_d       = wgt_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          mode_d  = mode;
          pix_d   = pixels;
          wgt_d   = weights;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        if (cnt_q == last_cnt) begin
          result_d    = post_val;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          acc_d = acc_q + mac_sum;
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
    // Registered so in_ready stays low while reset is held
    in_ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mode_q      <= 1'b0;
      pix_q       <= '0;
      wgt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mode_q      <= mode_d;
      pix_q       <= pix_d;
      wgt_q       <= wgt_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_conv_kernel_mac.sv
// Directed testbench for conv_kernel_mac with default parameters
// (NBITS=20, NMUL=3, SHIFT=0). Expected results follow CONV_RELU_EN.
module tb_conv_kernel_mac;

  localparam int NB = 20;

  logic                clock;
  logic                reset;
  logic                mode;
  logic                in_valid;
  logic                in_ready;
  logic [0:24][NB-1:0] pixels;
  logic [0:24][NB-1:0] weights;
  logic                out_valid;
  logic                out_ready;
  logic [NB-1:0]       result;
  logic                busy;

  int n_vec;
  int n_err;

  conv_kernel_mac dut (
    .clock     (clock),
    .reset     (reset),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pixels    (pixels),
    .weights   (weights),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Launch one window from a negedge with in_ready high, check latency and
  // result, then consume the result. Returns at a negedge.
  task automatic do_job(input logic m, input int exp_lat, input logic [NB-1:0] exp_res,
                        input string name);
    int lat;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
    end
    mode = m; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s after accept: busy=%b in_ready=%b want 1/0", name, busy, in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    n_vec++;
    if (lat !== exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    n_vec++;
    if (result !== exp_res) begin
      n_err++;
      $display("FAIL %s result: got %h want %h", name, result, exp_res);
    end
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s release: out_valid=%b busy=%b in_ready=%b want 0/0/1",
               name, out_valid, busy, in_ready);
    end
    @(negedge clock);
  endtask

  task automatic load_basic();
    for (int k = 0; k < 25; k++) begin
      pixels[k]  = 20'd1;
      weights[k] = (k < 9) ? 20'(k + 1) : 20'd7;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0;
    pixels = '0; weights = '0;
    repeat (3) @(posedge clock);
    #1;
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b result=%h busy=%b want 0/0/0/0",
               in_ready, out_valid, result, busy);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    n_vec++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
    @(negedge clock);
  endtask

  task automatic test_basic();
    load_basic();
    do_job(1'b0, 4, 20'd45, "basic_3x3");
  endtask

  task automatic test_modes();
    for (int k = 0; k < 25; k++) begin
      pixels[k]  = 20'(k);
      weights[k] = 20'd1;
    end
    do_job(1'b1, 10, 20'd300, "ramp_5x5");
    do_job(1'b0, 4, 20'd36, "ramp_3x3");
  endtask

  task automatic test_saturation();
    logic [NB-1:0] exp_neg;
    for (int k = 0; k < 25; k++) begin
      pixels[k]  = 20'h7FFFF;
      weights[k] = 20'h7FFFF;
    end
    do_job(1'b0, 4, 20'h7FFFF, "sat_pos");
    for (int k = 0; k < 25; k++) weights[k] = 20'h80001;
`ifdef CONV_RELU_EN
    exp_neg = 20'h00000;
`else
    exp_neg = 20'h80000;
`endif
    do_job(1'b0, 4, exp_neg, "sat_neg");
  endtask

  task automatic test_negative();
    logic [NB-1:0] exp_v;
    for (int k = 0; k < 25; k++) begin
      pixels[k]  = 20'hFFFFF;
      weights[k] = 20'd1;
    end
`ifdef CONV_RELU_EN
    exp_v = 20'h00000;
`else
    exp_v = 20'hFFFF7;
`endif
    do_job(1'b0, 4, exp_v, "neg_small");
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [NB-1:0] held;
    load_basic();
    mode = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    n_vec++;
    if (lat !== 4) begin
      n_err++;
      $display("FAIL hold_latency: got %0d want 4", lat);
    end
    held = result;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      n_vec++;
      if (out_valid !== 1'b1 || result !== 20'd45 || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL hold_cycle%0d: out_valid=%b result=%h in_ready=%b busy=%b want 1/2d/0/1",
                 c, out_valid, result, in_ready, busy);
      end
    end
    n_vec++;
    if (held !== 20'd45) begin
      n_err++;
      $display("FAIL hold_value: got %h want 2d", held);
    end
    // Release and present the next window in the same cycle
    @(negedge clock);
    for (int k = 0; k < 25; k++) begin
      pixels[k]  = 20'd2;
      weights[k] = 20'd3;
    end
    out_ready = 1'b1; in_valid = 1'b1; mode = 1'b0;
    @(posedge clock); #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle: out_valid=%b in_ready=%b busy=%b want 0/1/0",
               out_valid, in_ready, busy);
    end
    @(negedge clock);
    out_ready = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_accept: busy=%b in_ready=%b want 1/0", busy, in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    n_vec++;
    if (lat !== 4 || result !== 20'd54) begin
      n_err++;
      $display("FAIL b2b_result: lat=%0d result=%h want 4/36", lat, result);
    end
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int seen;
    for (int k = 0; k < 25; k++) begin
      pixels[k]  = 20'(k);
      weights[k] = 20'd1;
    end
    mode = 1'b1; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_values: in_ready=%b out_valid=%b result=%h busy=%b want 0/0/0/0",
               in_ready, out_valid, result, busy);
    end
    @(negedge clock);
    reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clock); #1;
      if (out_valid === 1'b1) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL midreset_stale: out_valid cycles got %0d want 0", seen);
    end
    @(negedge clock);
    load_basic();
    do_job(1'b0, 4, 20'd45, "after_reset");
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_modes();
    test_saturation();
    test_negative();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
